// File: rtl/io_port_pkg.sv
// Shared constants for the CPU port-bus I/O responder: register offsets, bit positions, word width.
package io_port_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] IO_DATA   = 2'd0;
    localparam logic [1:0] IO_STATUS = 2'd1;
    localparam logic [1:0] IO_CTRL   = 2'd2;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_AVAIL = 2;
    localparam int ST_RX_OVR   = 3;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLR_OVR = 1;
    localparam int CTRL_FLUSH   = 2;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [1:0] off;
    } io_req_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with flush; head word is read straight from the storage flops.
module io_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wp, rp;
    logic                    do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wp] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/cpu_io_port.sv
// Port-bus responder for OUT/IN: TX FIFO to a downstream sink, RX holding register from a source.
// Define IO_IRQ_EN to build the irq output and the CTRL irq_en bit.
module cpu_io_port
    import io_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0010,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       base,
    input  logic [DATA_W-1:0] data,
    input  logic              out_stb,
    input  logic              in_stb,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_hit,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
`ifdef IO_IRQ_EN
    ,
    output logic              irq
`endif
);
    io_req_t                     req;
    logic                        in_range;
    logic [15:0]                 off_full;
    logic                        data_wr, data_rd, ctrl_wr, capture;
    logic                        tx_full, tx_empty;
    logic [$clog2(FIFO_DEPTH):0] tx_count;
    logic [7:0]                  cnt8;
    logic [3:0]                  cnt_sat;
    logic [DATA_W-1:0]           rx_hold, status, ctrl_rd, rd_val;
    logic                        rx_full, overrun, irq_en;

    // Range check before trusting the subtraction, so addresses below base never wrap in.
    always_comb begin
        req      = '0;
        off_full = base - BASE_ADDR;
        in_range = (base >= BASE_ADDR) && (off_full < 16'd3);
        if (in_range) begin
            req.off = off_full[1:0];
            req.wr  = out_stb;
            req.rd  = in_stb & ~out_stb;
        end
    end

    assign data_wr = req.wr && (req.off == IO_DATA);
    assign data_rd = req.rd && (req.off == IO_DATA);
    assign ctrl_wr = req.wr && (req.off == IO_CTRL);
    assign capture = rx_valid & ~rx_full;
    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;

    io_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_txq (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .pop   (tx_valid & tx_ready),
        .flush (ctrl_wr & data[CTRL_FLUSH]),
        .wdata (data),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign cnt8    = 8'(tx_count);
    assign cnt_sat = (cnt8 > 8'd15) ? 4'hF : cnt8[3:0];

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_AVAIL] = rx_full;
        status[ST_RX_OVR]   = overrun;
        status[7:4]         = cnt_sat;
        ctrl_rd             = '0;
        ctrl_rd[CTRL_IRQ_EN] = irq_en;
        case (req.off)
            IO_DATA:   rd_val = rx_full ? rx_hold : '0;
            IO_STATUS: rd_val = status;
            IO_CTRL:   rd_val = ctrl_rd;
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata <= '0;
            io_hit   <= 1'b0;
            rx_hold  <= '0;
            rx_full  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            io_hit <= (out_stb | in_stb) & in_range;
            if (req.rd)
                io_rdata <= rd_val;
            if (capture)
                rx_hold <= rx_data;
            // Capture only happens when empty, so a same-cycle read sees the old state.
            if (capture)
                rx_full <= 1'b1;
            else if (data_rd)
                rx_full <= 1'b0;
            // A fresh overrun wins over a same-cycle clear so the event is not lost.
            if (rx_valid && rx_full && !data_rd)
                overrun <= 1'b1;
            else if (ctrl_wr && data[CTRL_CLR_OVR])
                overrun <= 1'b0;
        end
    end

`ifdef IO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr)
                irq_en <= data[CTRL_IRQ_EN];
            irq <= irq_en & (rx_full | overrun);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_io_port.sv
// Scoreboard bench for cpu_io_port: expected TX words and read data are queued at stimulus time.
module tb_cpu_io_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] base = '0, data = '0, rx_data = '0;
    logic        out_stb = 1'b0, in_stb = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
    logic [15:0] io_rdata, tx_data;
    logic        io_hit, tx_valid, rx_ready;
`ifdef IO_IRQ_EN
    logic        irq;
`endif

    int passed = 0;
    int total  = 0;
    logic [15:0] txq[$];
    logic [15:0] rdq[$];
    logic [15:0] q, exp;
    logic        h;

    cpu_io_port #(.BASE_ADDR(16'h0010), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .base     (base),
        .data     (data),
        .out_stb  (out_stb),
        .in_stb   (in_stb),
        .io_rdata (io_rdata),
        .io_hit   (io_hit),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
`ifdef IO_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        base = a; data = d; out_stb = 1'b1;
        @(negedge clk);
        out_stb = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] qq, output logic hh);
        base = a; in_stb = 1'b1;
        @(negedge clk);
        in_stb = 1'b0;
        qq = io_rdata; hh = io_hit;
    endtask

    task automatic rx_send(input logic [15:0] d);
        rx_data = d; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (io_rdata !== 16'h0) $display("FAIL reset_rdata: got %h want 0000", io_rdata); else passed++;
        total++; if (io_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", io_hit); else passed++;
        total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else passed++;
        total++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b want 1", rx_ready); else passed++;
        rdq.push_back(16'h0002);
        rd(16'h0011, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL reset_status: got %h want %h", q, exp); else passed++;
        total++; if (h !== 1'b1) $display("FAIL reset_status_hit: got %b want 1", h); else passed++;
    endtask

    task automatic test_tx_order();
        int n, want;
        wr(16'h0010, 16'hA5A5); txq.push_back(16'hA5A5);
        wr(16'h0010, 16'h1234); txq.push_back(16'h1234);
        rdq.push_back(16'h0020);
        rd(16'h0011, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL tx_status2: got %h want %h", q, exp); else passed++;
        total++; if (tx_data !== txq[0]) $display("FAIL tx_head: got %h want %h", tx_data, txq[0]); else passed++;
        want = txq.size(); n = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 20 && tx_valid; c++) begin
            exp = (txq.size() > 0) ? txq.pop_front() : 16'hxxxx;
            total++; if (tx_data !== exp) $display("FAIL tx_drain_word: got %h want %h", tx_data, exp); else passed++;
            n++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        total++; if (n !== want) $display("FAIL tx_drain_count: got %0d want %0d", n, want); else passed++;
        total++; if (tx_valid !== 1'b0) $display("FAIL tx_valid_after: got %b want 0", tx_valid); else passed++;
    endtask

    task automatic test_fifo_full();
        int n, want;
        for (int i = 0; i < 9; i++) begin
            wr(16'h0010, 16'h0100 + 16'(i));
            if (i < 8) txq.push_back(16'h0100 + 16'(i));
        end
        rdq.push_back(16'h0081);
        rd(16'h0011, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL full_status: got %h want %h", q, exp); else passed++;
        tx_ready = 1'b1;
        exp = txq.pop_front();
        total++; if (tx_data !== exp) $display("FAIL full_pushpop_head: got %h want %h", tx_data, exp); else passed++;
        txq.push_back(16'h0ABC);
        wr(16'h0010, 16'h0ABC);
        tx_ready = 1'b0;
        rdq.push_back(16'h0081);
        rd(16'h0011, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL full_pushpop_status: got %h want %h", q, exp); else passed++;
        want = txq.size(); n = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 20 && tx_valid; c++) begin
            exp = (txq.size() > 0) ? txq.pop_front() : 16'hxxxx;
            total++; if (tx_data !== exp) $display("FAIL full_drain_word: got %h want %h", tx_data, exp); else passed++;
            n++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        total++; if (n !== want) $display("FAIL full_drain_count: got %0d want %0d", n, want); else passed++;
    endtask

    task automatic test_flush();
        wr(16'h0010, 16'h1111);
        wr(16'h0010, 16'h2222);
        wr(16'h0012, 16'h0004);
        total++; if (tx_valid !== 1'b0) $display("FAIL flush_tx_valid: got %b want 0", tx_valid); else passed++;
        rdq.push_back(16'h0002);
        rd(16'h0011, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL flush_status: got %h want %h", q, exp); else passed++;
    endtask

    task automatic test_rx();
        rx_send(16'hBEEF);
        total++; if (rx_ready !== 1'b0) $display("FAIL rx_ready_full: got %b want 0", rx_ready); else passed++;
        rdq.push_back(16'hBEEF);
        rd(16'h0010, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL rx_read: got %h want %h", q, exp); else passed++;
        total++; if (rx_ready !== 1'b1) $display("FAIL rx_ready_after_read: got %b want 1", rx_ready); else passed++;
        rdq.push_back(16'h0000);
        rd(16'h0010, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL rx_empty_read: got %h want %h", q, exp); else passed++;
        // capture and DATA read in the same cycle: read sees empty, word is kept
        rx_data = 16'hCAFE; rx_valid = 1'b1;
        rdq.push_back(16'h0000);
        rd(16'h0010, q, h);
        rx_valid = 1'b0;
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL rx_same_cycle_read: got %h want %h", q, exp); else passed++;
        total++; if (rx_ready !== 1'b0) $display("FAIL rx_same_cycle_kept: got %b want 0", rx_ready); else passed++;
        rdq.push_back(16'hCAFE);
        rd(16'h0010, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL rx_kept_word: got %h want %h", q, exp); else passed++;
        rx_send(16'h1111);
        rx_send(16'h2222);
        rdq.push_back(16'h000E);
        rd(16'h0011, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL rx_overrun_status: got %h want %h", q, exp); else passed++;
        wr(16'h0012, 16'h0002);
        rdq.push_back(16'h0006);
        rd(16'h0011, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL rx_overrun_clear: got %h want %h", q, exp); else passed++;
        rdq.push_back(16'h1111);
        rd(16'h0010, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL rx_overrun_keeps_old: got %h want %h", q, exp); else passed++;
    endtask

    task automatic test_decode();
        logic [15:0] last;
        last = 16'h1111;
        wr(16'h0013, 16'h0004);
        rd(16'h0013, q, h);
        total++; if (q !== last) $display("FAIL dec_13_rdata: got %h want %h", q, last); else passed++;
        total++; if (h !== 1'b0) $display("FAIL dec_13_hit: got %b want 0", h); else passed++;
        wr(16'h000F, 16'h5555);
        rd(16'h000F, q, h);
        total++; if (q !== last) $display("FAIL dec_0F_rdata: got %h want %h", q, last); else passed++;
        total++; if (h !== 1'b0) $display("FAIL dec_0F_hit: got %b want 0", h); else passed++;
        total++; if (tx_valid !== 1'b0) $display("FAIL dec_no_push: got %b want 0", tx_valid); else passed++;
        // write and read strobed together: write wins, read ignored
        base = 16'h0010; data = 16'h7777; out_stb = 1'b1; in_stb = 1'b1;
        txq.push_back(16'h7777);
        @(negedge clk);
        out_stb = 1'b0; in_stb = 1'b0;
        total++; if (io_rdata !== last) $display("FAIL dec_both_rdata: got %h want %h", io_rdata, last); else passed++;
        exp = txq.pop_front();
        total++; if (tx_data !== exp || tx_valid !== 1'b1) $display("FAIL dec_both_push: got %h/%b want %h/1", tx_data, tx_valid, exp); else passed++;
        wr(16'h0012, 16'h0004);
    endtask

    task automatic test_reset_mid();
        wr(16'h0010, 16'h5A5A);
        rx_send(16'h3333);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (tx_valid !== 1'b0) $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); else passed++;
        total++; if (rx_ready !== 1'b1) $display("FAIL midrst_rx_ready: got %b want 1", rx_ready); else passed++;
        total++; if (io_rdata !== 16'h0) $display("FAIL midrst_rdata: got %h want 0000", io_rdata); else passed++;
    endtask

`ifdef IO_IRQ_EN
    task automatic test_irq();
        wr(16'h0012, 16'h0001);
        rdq.push_back(16'h0001);
        rd(16'h0012, q, h);
        exp = rdq.pop_front();
        total++; if (q !== exp) $display("FAIL irq_ctrl_read: got %h want %h", q, exp); else passed++;
        rx_send(16'h4242);
        @(negedge clk);
        total++; if (irq !== 1'b1) $display("FAIL irq_set: got %b want 1", irq); else passed++;
        rd(16'h0010, q, h);
        @(negedge clk);
        total++; if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_tx_order();
        test_fifo_full();
        test_flush();
        test_rx();
        test_decode();
        test_reset_mid();
`ifdef IO_IRQ_EN
        test_irq();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Memory-mapped I/O responder on the CPU's port bus: the device side of the OUT and IN instructions.
- Decodes the 16-bit port address (base); OUT writes are pushed into a TX FIFO that drains to a downstream valid/ready sink.
- An upstream valid/ready source fills an RX holding register, which an IN read returns on the CPU input bus.
- Sits between the CPU core and external peripherals (display, UART shim, etc.).

Parameters:
- BASE_ADDR, 16'h0010, port address of register 0; registers occupy BASE_ADDR..BASE_ADDR+2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.
- DATA_W, 16, data width; fixed to CPU word width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- base  in  16  port address from CPU
- data  in  16  write data from CPU (OUT)
- out_stb  in  1  one-cycle write strobe qualifying base/data
- in_stb  in  1  one-cycle read strobe qualifying base
- io_rdata  out  16  read data to CPU input bus
- io_hit  out  1  previous-cycle strobe matched this block's address range
- tx_data  out  16  FIFO head word
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  sink accepts head when tx_valid and tx_ready are both high
- rx_data  in  16  word from source
- rx_valid  in  1  source word valid
- rx_ready  out  1  holding register empty
- irq  out  1  interrupt request (only with IO_IRQ_EN)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: io_rdata=0, io_hit=0, tx_valid=0, rx_ready=1, irq=0, FIFO empty, RX holding empty, overrun=0, irq_en=0.
- Register map (offset = base - BASE_ADDR):
  - 0 DATA: write pushes data into the TX FIFO; read returns the RX word and empties the holding register.
  - 1 STATUS (read-only): bit0 tx_full, bit1 tx_empty, bit2 rx_avail, bit3 rx_overrun, bits7:4 FIFO count (saturating at 15), bits15:8 = 0.
  - 2 CTRL: write bit0 irq_en, bit1 clear overrun (self-clearing), bit2 flush TX FIFO (self-clearing). Read returns {15'b0, irq_en}.
- Address decode and strobe rules:
  - Offsets ≥3 or below BASE_ADDR are ignored: no state change, io_rdata holds, io_hit=0.
  - out_stb and in_stb high in the same cycle: the write takes effect, the read is ignored.
- Read latency: io_rdata is registered, 1 cycle after in_stb, and holds until the next matched read. io_hit pulses for exactly that cycle.
- TX FIFO:
  - Push on a DATA write; pop on tx_valid and tx_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full; count is unchanged.
  - Push while full and not popping: word dropped, FIFO unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Flush empties the FIFO in one cycle and overrides a simultaneous push or pop.
  - tx_data is the registered head word, valid whenever tx_valid=1.
- RX path:
  - rx_ready = holding register empty.
  - A word is captured on rx_valid and rx_ready.
  - A DATA read of an empty holding register returns 16'h0000 and has no side effects.
  - A DATA read in the same cycle as a capture returns the old (stale) value; the new word is kept.
- Overrun: set when rx_valid=1 while the holding register is full and no DATA read occurs in that cycle. Sticky until a CTRL clear.
- Reset mid-transfer: FIFO contents are discarded; downstream must tolerate tx_valid dropping.

Optional Feature:
- IO_IRQ_EN defined: irq = irq_en & (rx_avail | rx_overrun), registered, 1 cycle after the cause.
- IO_IRQ_EN undefined: the irq port is absent, CTRL bit0 is reserved and reads 0, and no irq logic is built.

Decomposition:
- Package io_port_pkg: register offset constants (IO_DATA=0, IO_STATUS=1, IO_CTRL=2), STATUS/CTRL bit-position constants, and the DATA_W constant.
- Sub-module io_fifo: synchronous FIFO with push, pop, flush, full, empty and count outputs; parameterised by depth and width.
- Address decode and the register file stay in cpu_io_port.

Test Plan:
- Reset → io_rdata=0, tx_valid=0, rx_ready=1. Read STATUS (base=16'h0011) → 16'h0002 one cycle later, io_hit=1.
- Write 16'hA5A5, 16'h1234 to 16'h0010 with tx_ready=0 → STATUS=16'h0020, tx_data=16'hA5A5. Raise tx_ready for 2 cycles → words emerge in order, tx_valid=0 after.
- 9 writes with tx_ready=0, FIFO_DEPTH=8 → count 8, tx_full=1, 9th word absent from the drain. Then push+pop in the same cycle while full → count stays 8.
- rx_valid with rx_data=16'hBEEF → rx_ready=0 next cycle. Read DATA → io_rdata=16'hBEEF, rx_ready=1. A second rx word while full and unread → STATUS bit3=1; CTRL write 16'h0002 clears it.
- Strobe at base=16'h0013 and 16'h000F → no state change, io_hit=0, io_rdata unchanged.
- IO_IRQ_EN: CTRL=16'h0001, then an rx word → irq=1 one cycle after capture; DATA read → irq=0.
